// File: rtl/veer_types.sv
// Shared types for the decode trigger pipeline.
// Each stage carries one match vector per issue slot.
package veer_types;

  localparam int NUM_TRIG = 4;

  typedef struct packed {
    logic [NUM_TRIG-1:0] i0;
    logic [NUM_TRIG-1:0] i1;
  } trig_stage_pkt_t;

endpackage

// File: rtl/dec_trigger_chain.sv
// Applies trigger chaining to one slot's WB match vector (DEC_TRIGGER_CHAIN_EN).
// Latency: combinational.
// Backpressure: none.
module dec_trigger_chain
  import veer_types::*;
(
  input  logic [NUM_TRIG-1:0] match_i,
  input  logic [1:0]          chain_i,
  output logic [NUM_TRIG-1:0] match_o
);

`ifdef DEC_TRIGGER_CHAIN_EN
  // A chained pair fires only as a unit: both members matched, or neither reports.
  always_comb begin
    match_o = match_i;
    for (int k = 0; k < NUM_TRIG/2; k++) begin
      if (chain_i[k]) begin
        match_o[2*k]   = match_i[2*k] & match_i[2*k+1];
        match_o[2*k+1] = match_i[2*k] & match_i[2*k+1];
      end
    end
  end
`else
  logic chain_unused;
  assign chain_unused = ^chain_i;
  assign match_o      = match_i;
`endif

endmodule

// File: rtl/dec_trigger_dffe.sv
// Asynchronous-reset flop cell with load enable.
// Latency: 1 cycle when enabled; holds its value while en is low.
// Backpressure: none of its own; the caller drives en from the stall.
module dec_trigger_dffe #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      dout <= '0;
    end else if (en) begin
      dout <= din;
    end
  end

endmodule

// File: rtl/dec_trigger_pipe.sv
// Carries per-slot trigger matches D->E1..E4->WB, reports at WB, keeps sticky hit status.
// Latency: a match at D reports at WB 5 cycles later; chaining needs DEC_TRIGGER_CHAIN_EN.
// Backpressure: dec_freeze holds every stage and blanks WB reports; dec_flush overrides it.
module dec_trigger_pipe #(
  parameter int NUM_TRIG = veer_types::NUM_TRIG
) (
  input  logic                clk,
  input  logic                rst_l,
  input  logic [NUM_TRIG-1:0] dec_i0_trigger_match_d,
  input  logic [NUM_TRIG-1:0] dec_i1_trigger_match_d,
  input  logic                dec_i0_valid_d,
  input  logic                dec_i1_valid_d,
  input  logic                dec_freeze,
  input  logic                dec_flush,
  input  logic [1:0]          trigger_chain,
  input  logic [NUM_TRIG-1:0] trigger_hit_clr,
  output logic [NUM_TRIG-1:0] dec_tlu_i0_trigger_wb,
  output logic [NUM_TRIG-1:0] dec_tlu_i1_trigger_wb,
  output logic                dec_tlu_trigger_any_wb,
  output logic [NUM_TRIG-1:0] trigger_hit_sts
);

  import veer_types::trig_stage_pkt_t;

  localparam int NSTG = 5;  // E1, E2, E3, E4, WB

  trig_stage_pkt_t     stg_d [NSTG];
  trig_stage_pkt_t     stg_q [NSTG];
  logic                stg_en;
  logic                rpt_en;
  logic [NUM_TRIG-1:0] i0_chn;
  logic [NUM_TRIG-1:0] i1_chn;
  logic [NUM_TRIG-1:0] i0_rpt;
  logic [NUM_TRIG-1:0] i1_rpt;
  logic [NUM_TRIG-1:0] hit_sts_d;
  logic [NUM_TRIG-1:0] hit_sts_q;

  assign stg_en = dec_flush | ~dec_freeze;

  // Flush kills everything younger than WB, including what would move into WB.
  always_comb begin
    for (int s = 0; s < NSTG; s++) begin
      stg_d[s] = '0;
    end
    if (!dec_flush) begin
      stg_d[0].i0 = dec_i0_trigger_match_d & {NUM_TRIG{dec_i0_valid_d}};
      stg_d[0].i1 = dec_i1_trigger_match_d & {NUM_TRIG{dec_i1_valid_d}};
      for (int s = 1; s < NSTG; s++) begin
        stg_d[s] = stg_q[s-1];
      end
    end
  end

  for (genvar s = 0; s < NSTG; s++) begin : g_stg
    dec_trigger_dffe #(.WIDTH($bits(trig_stage_pkt_t))) u_stg_ff (
      .clk  (clk),
      .rst_l(rst_l),
      .en   (stg_en),
      .din  (stg_d[s]),
      .dout (stg_q[s])
    );
  end

  dec_trigger_chain u_chain_i0 (
    .match_i(stg_q[NSTG-1].i0),
    .chain_i(trigger_chain),
    .match_o(i0_chn)
  );

  dec_trigger_chain u_chain_i1 (
    .match_i(stg_q[NSTG-1].i1),
    .chain_i(trigger_chain),
    .match_o(i1_chn)
  );

  // A held WB entry reports once, on the cycle the stall releases.
  assign rpt_en = ~dec_freeze | dec_flush;
  assign i0_rpt = rpt_en ? i0_chn : '0;
  assign i1_rpt = (rpt_en && (i0_chn == '0)) ? i1_chn : '0;

  assign hit_sts_d = (hit_sts_q & ~trigger_hit_clr) | i0_rpt | i1_rpt;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      hit_sts_q <= '0;
    end else begin
      hit_sts_q <= hit_sts_d;
    end
  end

  assign dec_tlu_i0_trigger_wb  = i0_rpt;
  assign dec_tlu_i1_trigger_wb  = i1_rpt;
  assign dec_tlu_trigger_any_wb = |{i0_rpt, i1_rpt};
  assign trigger_hit_sts        = hit_sts_q;

endmodule

// File: tb/tb_dec_trigger_pipe.sv
// Directed stimulus with a queue-based scoreboard for dec_trigger_pipe.
module tb_dec_trigger_pipe;

  logic       clk = 1'b0;
  logic       rst_l;
  logic [3:0] i0_m, i1_m, hit_clr;
  logic       i0_v, i1_v, freeze, flush;
  logic [1:0] chain;
  logic [3:0] i0_wb, i1_wb, hit_sts;
  logic       any_wb;

  typedef struct {
    int         cyc;
    logic [3:0] i0;
    logic [3:0] i1;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dec_trigger_pipe dut (
    .clk                   (clk),
    .rst_l                 (rst_l),
    .dec_i0_trigger_match_d(i0_m),
    .dec_i1_trigger_match_d(i1_m),
    .dec_i0_valid_d        (i0_v),
    .dec_i1_valid_d        (i1_v),
    .dec_freeze            (freeze),
    .dec_flush             (flush),
    .trigger_chain         (chain),
    .trigger_hit_clr       (hit_clr),
    .dec_tlu_i0_trigger_wb (i0_wb),
    .dec_tlu_i1_trigger_wb (i1_wb),
    .dec_tlu_trigger_any_wb(any_wb),
    .trigger_hit_sts       (hit_sts)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic chk_hit_at(input int c, input logic [3:0] e);
    wait_to(c);
    @(negedge clk);
    chk("hit_sts", {28'd0, hit_sts}, {28'd0, e});
  endtask

  task automatic drv(input logic v0, input logic [3:0] m0, input logic v1, input logic [3:0] m1);
    i0_v = v0; i0_m = m0; i1_v = v1; i1_m = m1;
  endtask

  task automatic push(input int c, input logic [3:0] e0, input logic [3:0] e1);
    exp_t e;
    e.cyc = c; e.i0 = e0; e.i1 = e1;
    q.push_back(e);
  endtask

  // Monitor: every WB report must match the head of the scoreboard, on time.
  always @(negedge clk) begin
    exp_t e;
    if (rst_l) begin
      if (q.size() != 0 && q[0].cyc < cyc) begin
        e = q.pop_front();
        n_cmp++; n_bad++;
        $display("FAIL missing_report: nothing seen at cycle %0d, expected i0=%b i1=%b", e.cyc, e.i0, e.i1);
      end
      if (any_wb) begin
        if (q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_report: got i0=%b i1=%b at cycle %0d, expected none", i0_wb, i1_wb, cyc);
        end else begin
          e = q.pop_front();
          chk("wb_cycle", cyc, e.cyc);
          chk("i0_wb", {28'd0, i0_wb}, {28'd0, e.i0});
          chk("i1_wb", {28'd0, i1_wb}, {28'd0, e.i1});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int c;
    rst_l = 1'b0; freeze = 1'b0; flush = 1'b0; chain = 2'b00; hit_clr = 4'b0000;
    drv(1'b0, 4'b0000, 1'b0, 4'b0000);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_i0_wb", {28'd0, i0_wb}, 32'd0);
    chk("rst_i1_wb", {28'd0, i1_wb}, 32'd0);
    chk("rst_any", {31'd0, any_wb}, 32'd0);
    chk("rst_hit", {28'd0, hit_sts}, 32'd0);
    tick(); rst_l = 1'b1;
    tick(); tick();

    // Basic 5-cycle latency, hit set and clear
    c = cyc; drv(1'b1, 4'b0001, 1'b0, 4'b0000); push(c+5, 4'b0001, 4'b0000);
    tick(); drv(1'b0, 4'b0000, 1'b0, 4'b0000);
    chk_hit_at(c+6, 4'b0001);
    tick(); hit_clr = 4'b0001;
    tick(); hit_clr = 4'b0000;
    chk_hit_at(c+8, 4'b0000);

    // Flush kills an in-flight match; an invalid slot never captures
    tick(); c = cyc; drv(1'b1, 4'b0001, 1'b0, 4'b1111);
    tick(); drv(1'b0, 4'b0000, 1'b0, 4'b0000);
    tick(); flush = 1'b1;
    tick(); flush = 1'b0;
    chk_hit_at(c+7, 4'b0000);

    // Chain pair 0/1 on slot i1
    tick(); chain = 2'b01; c = cyc; drv(1'b0, 4'b0000, 1'b1, 4'b0001);
`ifndef DEC_TRIGGER_CHAIN_EN
    push(c+5, 4'b0000, 4'b0001);
`endif
    tick(); drv(1'b0, 4'b0000, 1'b1, 4'b0011); push(c+6, 4'b0000, 4'b0011);
    tick(); drv(1'b0, 4'b0000, 1'b0, 4'b0000);
    chk_hit_at(c+7, 4'b0011);

    // Both pairs chained, i0 0111
    tick(); chain = 2'b11; hit_clr = 4'b1111; c = cyc; drv(1'b1, 4'b0111, 1'b0, 4'b0000);
`ifdef DEC_TRIGGER_CHAIN_EN
    push(c+5, 4'b0011, 4'b0000);
`else
    push(c+5, 4'b0111, 4'b0000);
`endif
    tick(); hit_clr = 4'b0000; drv(1'b0, 4'b0000, 1'b0, 4'b0000);
    wait_to(c+6); chain = 2'b00;
`ifdef DEC_TRIGGER_CHAIN_EN
    chk_hit_at(c+6, 4'b0011);
`else
    chk_hit_at(c+6, 4'b0111);
`endif

    // Chain config is taken at WB, not at D
    tick(); hit_clr = 4'b1111; c = cyc; drv(1'b1, 4'b0001, 1'b0, 4'b0000);
    tick(); hit_clr = 4'b0000; drv(1'b0, 4'b0000, 1'b0, 4'b0000);
    wait_to(c+5); chain = 2'b01;
`ifdef DEC_TRIGGER_CHAIN_EN
    tick(); chain = 2'b00; chk_hit_at(c+6, 4'b0000);
`else
    push(c+5, 4'b0001, 4'b0000);
    tick(); chain = 2'b00; chk_hit_at(c+6, 4'b0001);
`endif

    // i0 report suppresses i1; i1 alone reports next cycle
    tick(); hit_clr = 4'b1111; c = cyc; drv(1'b1, 4'b0100, 1'b1, 4'b1000); push(c+5, 4'b0100, 4'b0000);
    tick(); hit_clr = 4'b0000; drv(1'b0, 4'b0000, 1'b1, 4'b1000); push(c+6, 4'b0000, 4'b1000);
    tick(); drv(1'b0, 4'b0000, 1'b0, 4'b0000);
    chk_hit_at(c+6, 4'b0100);
    chk_hit_at(c+7, 4'b1100);

    // Freeze for three cycles delays the report by three
    tick(); hit_clr = 4'b1111; c = cyc; drv(1'b1, 4'b0001, 1'b0, 4'b0000); push(c+8, 4'b0001, 4'b0000);
    tick(); hit_clr = 4'b0000; drv(1'b0, 4'b0000, 1'b0, 4'b0000);
    tick(); freeze = 1'b1;
    tick(); tick(); tick(); freeze = 1'b0;
    chk_hit_at(c+8, 4'b0000);
    chk_hit_at(c+9, 4'b0001);

    // Set wins over simultaneous clear
    tick(); c = cyc; drv(1'b1, 4'b0001, 1'b0, 4'b0000); push(c+5, 4'b0001, 4'b0000);
    tick(); drv(1'b0, 4'b0000, 1'b0, 4'b0000);
    wait_to(c+5); hit_clr = 4'b0001;
    tick(); hit_clr = 4'b0000;
    chk_hit_at(c+6, 4'b0001);
    tick(); hit_clr = 4'b0001;
    tick(); hit_clr = 4'b0000;
    chk_hit_at(c+8, 4'b0000);

    // Flush with freeze: WB still reports, younger entry dies
    tick(); c = cyc; drv(1'b1, 4'b0001, 1'b0, 4'b0000); push(c+5, 4'b0001, 4'b0000);
    tick(); drv(1'b1, 4'b0010, 1'b0, 4'b0000);
    tick(); drv(1'b0, 4'b0000, 1'b0, 4'b0000);
    wait_to(c+5); freeze = 1'b1; flush = 1'b1;
    tick(); freeze = 1'b0; flush = 1'b0;
    chk_hit_at(c+6, 4'b0001);
    chk_hit_at(c+10, 4'b0001);

    // Reset mid-pipe clears WB, status and in-flight entries at once
    tick(); c = cyc; drv(1'b1, 4'b0010, 1'b0, 4'b0000); push(c+5, 4'b0010, 4'b0000);
    tick(); drv(1'b0, 4'b0000, 1'b0, 4'b0000);
    tick(); drv(1'b1, 4'b1000, 1'b0, 4'b0000);
    tick(); drv(1'b0, 4'b0000, 1'b0, 4'b0000);
    wait_to(c+5);
    @(negedge clk); #1;
    rst_l = 1'b0; #1;
    chk("arst_i0_wb", {28'd0, i0_wb}, 32'd0);
    chk("arst_any", {31'd0, any_wb}, 32'd0);
    chk("arst_hit", {28'd0, hit_sts}, 32'd0);
    tick(); tick(); rst_l = 1'b1;
    repeat (8) tick();
    @(negedge clk);
    chk("post_rst_hit", {28'd0, hit_sts}, 32'd0);

    tick(); tick();
    chk("scoreboard_empty", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dec_trigger_pipe.md
DEC_TRIGGER_PIPE -- requirements
Module: dec_trigger_pipe

Interface
REQ-001 Parameter NUM_TRIG, default 4, number of triggers; fixed at 4 (two chain pairs: 0/1, 2/3).
REQ-002 clk  input  1  core clock; the single clock of the block.
REQ-003 rst_l  input  1  reset; asynchronous, active-low.
REQ-004 dec_i0_trigger_match_d  input  4  per-trigger execute match for i0 at decode.
REQ-005 dec_i1_trigger_match_d  input  4  per-trigger execute match for i1 at decode.
REQ-006 dec_i0_valid_d, dec_i1_valid_d  input  1 each  instruction issued out of decode this cycle.
REQ-007 dec_freeze  input  1  pipeline stall; all stages hold.
REQ-008 dec_flush  input  1  kill all in-flight instructions younger than WB.
REQ-009 trigger_chain  input  2  bit k set: triggers 2k and 2k+1 are chained.
REQ-010 trigger_hit_clr  input  4  TLU write clearing sticky hit bit i.
REQ-011 dec_tlu_i0_trigger_wb, dec_tlu_i1_trigger_wb  output  4 each  triggers reported at WB.
REQ-012 dec_tlu_trigger_any_wb  output  1  OR of both WB report vectors.
REQ-013 trigger_hit_sts  output  4  sticky per-trigger hit status.

Function
REQ-014 Stages SHALL be D->E1->E2->E3->E4->WB; each stage carries i0[3:0] and i1[3:0] match vectors.
REQ-015 E1 capture SHALL be match_d AND its valid_d; an invalid slot captures 0.
REQ-016 A match at D in cycle n with no freeze/flush SHALL appear on the WB outputs in cycle n+5.
REQ-017 dec_freeze=1 SHALL hold every stage including WB; WB outputs SHALL be 0 while frozen (no double report).
REQ-018 dec_flush=1 in cycle n SHALL zero E1..E4 and the E1 capture at the next edge; WB contents of cycle n SHALL still report.
REQ-019 Flush and freeze in the same cycle: flush SHALL win.
REQ-020 Chain rule at WB, per slot: if trigger_chain[k]=1, bits 2k and 2k+1 SHALL both report only if both matched, else both 0.
REQ-021 If trigger_chain[k]=0, bits 2k and 2k+1 SHALL report independently.
REQ-022 If any i0 WB report bit is 1 after chaining, dec_tlu_i1_trigger_wb SHALL be 0 (i1 is younger).
REQ-023 trigger_hit_sts[i] SHALL set the cycle after bit i is reported in either slot.
REQ-024 trigger_hit_sts[i] SHALL clear the cycle after trigger_hit_clr[i]; simultaneous set and clear: set SHALL win.
REQ-025 Chain configuration SHALL be sampled at WB, not at D.

Reset
REQ-026 rst_l low SHALL asynchronously zero all stage registers and trigger_hit_sts; all outputs SHALL be 0 during and after reset until new matches arrive.
REQ-027 Reset deassertion mid-operation SHALL leave no residual in-flight hits.

Configuration
REQ-028 Macro DEC_TRIGGER_CHAIN_EN defined: REQ-020/021 chaining applies.
REQ-029 Macro DEC_TRIGGER_CHAIN_EN undefined: trigger_chain SHALL be ignored and all four triggers report independently; the port SHALL remain.

Structure
REQ-030 Package veer_types SHALL hold typedef trig_stage_pkt_t {i0[3:0], i1[3:0]} and constant NUM_TRIG=4.
REQ-031 One sub-module dec_trigger_chain SHALL implement the chain rule for one slot; instantiated twice (i0, i1).
REQ-032 Stage registers SHALL use the codebase asynchronous-reset flop cells with freeze as enable.

Verification
REQ-033 i0 valid, match_d=4'b0001 at cycle 10, no stalls -> i0_wb=4'b0001, any=1 at cycle 15; hit_sts=4'b0001 at 16.
REQ-034 i0 match 4'b0001 cycle 10, dec_flush at cycle 12 -> no report at 15; hit_sts stays 0.
REQ-035 chain=2'b01, i1 match 4'b0001 -> i1_wb=0; i1 match 4'b0011 -> i1_wb=4'b0011; with macro off, 4'b0001 -> 4'b0001.
REQ-036 i0 match 4'b0100 and i1 match 4'b1000 same cycle -> i0_wb=4'b0100, i1_wb=0, hit_sts=4'b0100.
REQ-037 Match at cycle 10, freeze cycles 12-14 -> WB report at cycle 18, exactly one cycle wide.
REQ-038 hit_sts=4'b0001, trigger_hit_clr=4'b0001 in the cycle bit 0 reports again -> hit_sts stays 4'b0001; rst_l low mid-pipe -> all outputs 0 immediately.
